sdft_frame_scheduler: RTL and testbench
=======================================

Name: sdft_frame_scheduler

Overview:
- Sequences the sliding DFT core (`sdft`): forwards input samples to it as single-cycle update strobes.
- Every FRAME_LEN accepted samples, freezes updates and walks bin addresses 0..FREQ_BINS-1.
- Converts each bin to an |re|+|im| magnitude and streams it downstream over a valid/ready handshake.
- Sits between the sample source (ADC/deserialiser) and the sdft core, and between the core and the display/UART consumer.

Parameters:
- DATA_WIDTH, 8, sample width (signed).
- FREQ_BINS, 16, number of bins in the core; power of two, at least 2.
- BIN_WIDTH, 16, width of the core's signed real/imag bin outputs.
- FRAME_LEN, 16, accepted samples between scans; at least 1.
- READ_LAT, 1, cycles from bin_addr to valid bin_real/bin_imag; range 1..3.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sample_in  in  DATA_WIDTH  signed input sample.
- sample_valid  in  1  one-cycle strobe; sample_in is valid this cycle.
- sdft_sample  out  DATA_WIDTH  registered sample to the core.
- sdft_update  out  1  one-cycle strobe; the core consumes sdft_sample.
- bin_addr  out  clog2(FREQ_BINS)  bin read address to the core.
- bin_real  in  BIN_WIDTH  signed real part, READ_LAT after bin_addr.
- bin_imag  in  BIN_WIDTH  signed imaginary part.
- mag_data  out  BIN_WIDTH+1  unsigned |re|+|im|.
- mag_bin  out  clog2(FREQ_BINS)  bin index of mag_data.
- mag_last  out  1  high with the final bin of a frame.
- mag_valid  out  1  mag_data/mag_bin/mag_last valid.
- mag_ready  in  1  consumer accepts.
- busy  out  1  high in any state other than RUN.
- overrun  out  1  sticky; a sample was lost.

Behaviour:
- Reset values: sdft_sample=0, sdft_update=0, bin_addr=0, mag_*=0, busy=0, overrun=0, state RUN, sample counter 0, hold buffer empty.
- RUN state:
  - sample_valid registers sample_in into sdft_sample and pulses sdft_update on the next cycle. Latency is 1 cycle.
  - Each forwarded sample increments the counter.
  - When the counter reaches FRAME_LEN, clear the counter and go to SETTLE.
- SETTLE state: wait 1 cycle so the core finishes the final update, then go to ADDR with bin index k=0.
- ADDR state: drive bin_addr=k, then wait READ_LAT cycles in WAIT.
- WAIT → CALC:
  - Register magnitude = abs(bin_real)+abs(bin_imag), zero-extended to BIN_WIDTH+1.
  - abs(-2^(BIN_WIDTH-1)) = 2^(BIN_WIDTH-1); no saturation is needed.
  - Assert mag_valid with mag_bin=k and mag_last=(k==FREQ_BINS-1). Go to OUT.
- OUT state:
  - Hold all mag_* outputs stable until mag_valid&&mag_ready.
  - On that handshake, deassert mag_valid on the next cycle.
  - If k was last, go to DRAIN; otherwise k+1 and go to ADDR.
- DRAIN state:
  - If the hold buffer is full, forward its sample as an update (counted toward the next frame) and empty the buffer.
  - Return to RUN.
- mag_valid never drops without a handshake. mag_ready while mag_valid=0 is ignored.
- Samples arriving while busy=1:
  - The first is stored in a 1-entry hold buffer.
  - A further sample_valid while the buffer is full drops the new sample and sets overrun.
  - No sdft_update is issued while busy.
- overrun clears only on reset.
- A sample_valid in the same cycle the counter reaches FRAME_LEN is the final sample of that frame; it is not held.
- A sample_valid arriving in the DRAIN cycle while the buffer is full: the held sample is forwarded first. The new sample is held and forwarded on the first RUN cycle; it is not an overrun.
- Bin index wraps to 0 after a scan. bin_addr retains its last value outside a scan.
- Reset mid-scan aborts immediately: mag_valid drops, the partial frame is discarded, the hold buffer empties, and the counter clears.
- The core's own reset is driven from the same reset net; this block issues no other reset.

Decomposition:
- Shared package `sdft_pkg`:
  - state enum: RUN, SETTLE, ADDR, WAIT, CALC, OUT, DRAIN.
  - function clog2 and ADDR_WIDTH = clog2(FREQ_BINS).
  - magnitude width function BIN_WIDTH+1.
- One natural sub-module, `sdft_abs_sum`: combinational |a|+|b| for two signed BIN_WIDTH operands, reusable by later power/peak-detect blocks.
- FSM, counters and hold buffer stay in the top module.

Test Plan:
- Config for all scenarios: FREQ_BINS=4, FRAME_LEN=4, READ_LAT=1. The core is modelled by a bench stub returning re=10*k, im=-3*k.
- Basic frame: 4 spaced samples → 4 sdft_update pulses, each 1 cycle after its sample_valid. Then mag stream (0,0), (1,13), (2,26), (3,39), with mag_last only on bin 3.
- Backpressure: mag_ready low for 5 cycles on bin 2 → mag_data=26 and mag_bin=2 held stable; no bin_addr advance; frame completes after mag_ready returns high.
- Extreme values: stub returns re=-32768, im=-32768 → mag_data=65536 (17 bits), no wrap.
- Sample during scan: 1 sample mid-scan → held; forwarded as sdft_update in DRAIN; counter=1 after return; overrun stays 0. 2 samples mid-scan → overrun=1; exactly 1 sample forwarded.
- Reset mid-scan: assert reset while in OUT on bin 1 → mag_valid=0 and busy=0 immediately. After release, 4 new samples produce a full frame starting at bin 0.

Source files
------------

// File: rtl/sdft_pkg.sv
// Shared types and sizing helpers for the sliding-DFT scheduling blocks.
package sdft_pkg;

   // Scheduler phases: forward samples, let the core settle, then scan every bin.
   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_SETTLE = 3'd1,
      ST_ADDR   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_CALC   = 3'd4,
      ST_OUT    = 3'd5,
      ST_DRAIN  = 3'd6
   } sched_state_t;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return w;
   endfunction

   // |re|+|im| of two signed operands needs one extra bit beyond the operand width.
   function automatic int mag_width(input int bin_width);
      return bin_width + 1;
   endfunction

   localparam int FREQ_BINS_DEFAULT  = 16;
   localparam int ADDR_WIDTH_DEFAULT = clog2(FREQ_BINS_DEFAULT);

endpackage

// File: rtl/sdft_abs_sum.sv
// Combinational |a|+|b| for two signed operands; the result is unsigned and
// one bit wider, so abs of the most negative value never wraps.
module sdft_abs_sum
   import sdft_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic signed [WIDTH-1:0]          a,
   input  logic signed [WIDTH-1:0]          b,
   output logic [mag_width(WIDTH)-1:0]      sum
);

   logic [WIDTH:0] a_ext_s;
   logic [WIDTH:0] b_ext_s;
   logic [WIDTH:0] a_abs_s;
   logic [WIDTH:0] b_abs_s;

   // Sign-extend by one bit, negate negatives, then add the two magnitudes.
   always_comb begin
      a_ext_s = {a[WIDTH-1], a};
      b_ext_s = {b[WIDTH-1], b};
      a_abs_s = a[WIDTH-1] ? (~a_ext_s + {{WIDTH{1'b0}}, 1'b1}) : a_ext_s;
      b_abs_s = b[WIDTH-1] ? (~b_ext_s + {{WIDTH{1'b0}}, 1'b1}) : b_ext_s;
      sum     = a_abs_s + b_abs_s;
   end

endmodule

// File: rtl/sdft_frame_scheduler.sv
// Feeds samples to the sliding DFT core as update strobes and, after every
// FRAME_LEN samples, scans all bins and streams |re|+|im| over valid/ready.
// Samples arriving during a scan are parked in a one-entry hold buffer.
module sdft_frame_scheduler
   import sdft_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FREQ_BINS  = 16,
   parameter int BIN_WIDTH  = 16,
   parameter int FRAME_LEN  = 16,
   parameter int READ_LAT   = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic signed [DATA_WIDTH-1:0]       sample_in,
   input  logic                               sample_valid,
   output logic signed [DATA_WIDTH-1:0]       sdft_sample,
   output logic                               sdft_update,
   output logic [clog2(FREQ_BINS)-1:0]        bin_addr,
   input  logic signed [BIN_WIDTH-1:0]        bin_real,
   input  logic signed [BIN_WIDTH-1:0]        bin_imag,
   output logic [mag_width(BIN_WIDTH)-1:0]    mag_data,
   output logic [clog2(FREQ_BINS)-1:0]        mag_bin,
   output logic                               mag_last,
   output logic                               mag_valid,
   input  logic                               mag_ready,
   output logic                               busy,
   output logic                               overrun
);

   localparam int ADDR_W = clog2(FREQ_BINS);
   localparam int MAG_W  = mag_width(BIN_WIDTH);
   localparam int CNT_W  = clog2(FRAME_LEN + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);
   localparam logic [ADDR_W-1:0] BIN_LAST = ADDR_W'(FREQ_BINS - 1);
   localparam logic [1:0]        LAT_LAST = 2'(READ_LAT - 1);

   sched_state_t                 state_r;
   logic [ADDR_W-1:0]            k_r;
   logic [CNT_W-1:0]             cnt_r;
   logic [1:0]                   lat_r;
   logic signed [DATA_WIDTH-1:0] hold_data_r;
   logic                         hold_full_r;

   logic                         fwd_s;
   logic signed [DATA_WIDTH-1:0] fwd_data_s;
   logic                         frame_done_s;
   logic [MAG_W-1:0]             mag_sum_s;

   sdft_abs_sum #(
      .WIDTH (BIN_WIDTH)
   ) u_abs_sum (
      .a   (bin_real),
      .b   (bin_imag),
      .sum (mag_sum_s)
   );

   // Pick what (if anything) goes to the core this cycle; a held sample always wins.
   always_comb begin
      fwd_s      = 1'b0;
      fwd_data_s = hold_data_r;
      case (state_r)
         ST_RUN: begin
            if (hold_full_r) begin
               fwd_s      = 1'b1;
               fwd_data_s = hold_data_r;
            end else if (sample_valid) begin
               fwd_s      = 1'b1;
               fwd_data_s = sample_in;
            end else begin
               fwd_s      = 1'b0;
               fwd_data_s = hold_data_r;
            end
         end
         ST_DRAIN: begin
            if (hold_full_r) begin
               fwd_s = 1'b1;
            end else begin
               fwd_s = 1'b0;
            end
         end
         default: begin
            fwd_s = 1'b0;
         end
      endcase
      frame_done_s = fwd_s && (cnt_r == CNT_LAST);
   end

   // Scheduler FSM: sample forwarding, frame counting, bin scan and magnitude output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_RUN;
         k_r         <= '0;
         cnt_r       <= '0;
         lat_r       <= 2'd0;
         sdft_sample <= '0;
         sdft_update <= 1'b0;
         bin_addr    <= '0;
         mag_data    <= '0;
         mag_bin     <= '0;
         mag_last    <= 1'b0;
         mag_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         sdft_update <= fwd_s;
         if (fwd_s) begin
            sdft_sample <= fwd_data_s;
            cnt_r       <= frame_done_s ? '0 : cnt_r + CNT_W'(1);
         end
         case (state_r)
            ST_RUN: begin
               if (frame_done_s) begin
                  state_r <= ST_SETTLE;
                  busy    <= 1'b1;
               end
            end
            ST_SETTLE: begin
               k_r     <= '0;
               state_r <= ST_ADDR;
            end
            ST_ADDR: begin
               bin_addr <= k_r;
               lat_r    <= 2'd0;
               state_r  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (lat_r == LAT_LAST) begin
                  state_r <= ST_CALC;
               end else begin
                  lat_r <= lat_r + 2'd1;
               end
            end
            ST_CALC: begin
               mag_data  <= mag_sum_s;
               mag_bin   <= k_r;
               mag_last  <= (k_r == BIN_LAST);
               mag_valid <= 1'b1;
               state_r   <= ST_OUT;
            end
            ST_OUT: begin
               if (mag_ready) begin
                  mag_valid <= 1'b0;
                  if (k_r == BIN_LAST) begin
                     k_r     <= '0;
                     state_r <= ST_DRAIN;
                  end else begin
                     k_r     <= k_r + ADDR_W'(1);
                     state_r <= ST_ADDR;
                  end
               end
            end
            ST_DRAIN: begin
               // A drained sample can itself complete a frame when FRAME_LEN is tiny.
               if (frame_done_s) begin
                  state_r <= ST_SETTLE;
               end else begin
                  state_r <= ST_RUN;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_r   <= ST_RUN;
               mag_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Hold buffer: parks one sample during a scan, flags overrun on a second one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_full_r <= 1'b0;
         hold_data_r <= '0;
         overrun     <= 1'b0;
      end else begin
         case (state_r)
            ST_RUN: begin
               // Held sample goes out now; a simultaneous new sample takes its place.
               if (hold_full_r) begin
                  hold_full_r <= sample_valid;
                  if (sample_valid) begin
                     hold_data_r <= sample_in;
                  end
               end
            end
            ST_DRAIN: begin
               // The slot is vacated this cycle, so a new arrival is never an overrun.
               hold_full_r <= sample_valid;
               if (sample_valid) begin
                  hold_data_r <= sample_in;
               end
            end
            default: begin
               if (sample_valid) begin
                  if (hold_full_r) begin
                     overrun <= 1'b1;
                  end else begin
                     hold_full_r <= 1'b1;
                     hold_data_r <= sample_in;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdft_frame_scheduler.sv
// Bench for sdft_frame_scheduler with a 4-bin, 4-sample-frame configuration.
module tb_sdft_frame_scheduler;

   localparam int NB = 4;
   localparam int FL = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [7:0]  sample_in;
   logic               sample_valid;
   logic signed [7:0]  sdft_sample;
   logic               sdft_update;
   logic [1:0]         bin_addr;
   logic signed [15:0] bin_real;
   logic signed [15:0] bin_imag;
   logic [16:0]        mag_data;
   logic [1:0]         mag_bin;
   logic               mag_last;
   logic               mag_valid;
   logic               mag_ready;
   logic               busy;
   logic               overrun;

   logic signed [15:0] re_tab [NB];
   logic signed [15:0] im_tab [NB];

   int n_vec  = 0;
   int n_fail = 0;

   // reference model state
   int                m_cnt;
   int                m_bin;
   int                n_hs;
   bit                m_busy;
   bit                m_drain;
   bit                m_over;
   logic signed [7:0] m_hold [$];
   logic [16:0]       cap_mag [NB];

   typedef struct {
      int bin;
      int re;
      int im;
      int exp_mag;
   } vec_t;
   vec_t vecs [8];

   int n;
   int held;
   int hs_before;

   sdft_frame_scheduler #(
      .DATA_WIDTH (8),
      .FREQ_BINS  (NB),
      .BIN_WIDTH  (16),
      .FRAME_LEN  (FL),
      .READ_LAT   (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sdft_sample  (sdft_sample),
      .sdft_update  (sdft_update),
      .bin_addr     (bin_addr),
      .bin_real     (bin_real),
      .bin_imag     (bin_imag),
      .mag_data     (mag_data),
      .mag_bin      (mag_bin),
      .mag_last     (mag_last),
      .mag_valid    (mag_valid),
      .mag_ready    (mag_ready),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   // Core stub: one-cycle registered bin read from the bench tables.
   always_ff @(posedge clk) begin
      bin_real <= re_tab[bin_addr];
      bin_imag <= im_tab[bin_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_mag(input int k);
      int r;
      int i;
      r = re_tab[k];
      i = im_tab[k];
      return (r < 0 ? -r : r) + (i < 0 ? -i : i);
   endfunction

   task automatic default_tab();
      for (int k = 0; k < NB; k++) begin
         re_tab[k] = 16'(10 * k);
         im_tab[k] = 16'(-3 * k);
      end
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      m_bin   = 0;
      m_busy  = 1'b0;
      m_drain = 1'b0;
      m_over  = 1'b0;
      m_hold.delete();
   endtask

   // What the next clock edge should do, from the frame/hold rules.
   task automatic model_edge(output bit fwd, output logic signed [7:0] fdat);
      fwd  = 1'b0;
      fdat = '0;
      if (!m_busy) begin
         if (m_hold.size() > 0) begin
            fwd  = 1'b1;
            fdat = m_hold.pop_front();
            if (sample_valid) m_hold.push_back(sample_in);
         end else if (sample_valid) begin
            fwd  = 1'b1;
            fdat = sample_in;
         end
      end else if (m_drain) begin
         if (m_hold.size() > 0) begin
            fwd  = 1'b1;
            fdat = m_hold.pop_front();
         end
         if (sample_valid) m_hold.push_back(sample_in);
         m_busy  = 1'b0;
         m_drain = 1'b0;
      end else if (sample_valid) begin
         if (m_hold.size() == 0) m_hold.push_back(sample_in);
         else m_over = 1'b1;
      end
      if (fwd) begin
         m_cnt++;
         if (m_cnt == FL) begin
            m_cnt  = 0;
            m_busy = 1'b1;
         end
      end
      if (mag_valid && mag_ready && mag_last) m_drain = 1'b1;
   endtask

   // One clock: scoreboard the handshake, advance the model, check after the edge.
   task automatic cycle();
      bit                fwd;
      logic signed [7:0] fdat;
      bit                stall;
      logic [16:0]       s_data;
      logic [1:0]        s_bin;
      logic              s_last;
      stall  = mag_valid && !mag_ready;
      s_data = mag_data;
      s_bin  = mag_bin;
      s_last = mag_last;
      fwd    = 1'b0;
      fdat   = '0;
      if (!reset) begin
         if (mag_valid && mag_ready) begin
            chk("hs_bin", 32'(mag_bin), 32'(m_bin));
            chk("hs_data", 32'(mag_data), 32'(model_mag(m_bin)));
            chk("hs_last", 32'(mag_last), 32'(m_bin == NB - 1));
            cap_mag[m_bin] = mag_data;
            m_bin = (m_bin + 1) % NB;
            n_hs++;
         end
         model_edge(fwd, fdat);
      end
      @(posedge clk);
      #1;
      if (reset) begin
         chk("rst_update", 32'(sdft_update), 32'(0));
         chk("rst_mag_valid", 32'(mag_valid), 32'(0));
         chk("rst_busy", 32'(busy), 32'(0));
      end else begin
         chk("update", 32'(sdft_update), 32'(fwd));
         if (fwd) chk("sample", 32'(sdft_sample), 32'(fdat));
         chk("busy", 32'(busy), 32'(m_busy));
         chk("overrun", 32'(overrun), 32'(m_over));
         if (stall) begin
            chk("stall_valid", 32'(mag_valid), 32'(1));
            chk("stall_data", 32'(mag_data), 32'(s_data));
            chk("stall_bin", 32'(mag_bin), 32'(s_bin));
            chk("stall_last", 32'(mag_last), 32'(s_last));
            chk("stall_addr", 32'(bin_addr), 32'(s_bin));
         end
         if (!m_busy && mag_valid) chk("valid_outside_scan", 32'(mag_valid), 32'(0));
      end
   endtask

   task automatic send(input logic signed [7:0] d);
      sample_in    = d;
      sample_valid = 1'b1;
      cycle();
      sample_valid = 1'b0;
      cycle();
      cycle();
   endtask

   task automatic wait_idle(input string name);
      int c;
      c = 0;
      while ((m_busy || busy) && c < 300) begin
         cycle();
         c++;
      end
      chk({"idle_timeout_", name}, 32'(c < 300), 32'(1));
   endtask

   initial begin
      vecs[0] = '{0, 0, 0, 0};
      vecs[1] = '{1, 10, -3, 13};
      vecs[2] = '{2, 20, -6, 26};
      vecs[3] = '{3, 30, -9, 39};
      vecs[4] = '{3, -32768, -32768, 65536};
      vecs[5] = '{2, 32767, -32768, 65535};
      vecs[6] = '{1, -1, 1, 2};
      vecs[7] = '{0, 32767, 32767, 65534};

      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_in    = '0;
      mag_ready    = 1'b0;
      n_hs         = 0;
      default_tab();
      model_reset();

      // reset values
      @(posedge clk);
      #1;
      chk("reset_sdft_sample", 32'(sdft_sample), 32'(0));
      chk("reset_sdft_update", 32'(sdft_update), 32'(0));
      chk("reset_bin_addr", 32'(bin_addr), 32'(0));
      chk("reset_mag_data", 32'(mag_data), 32'(0));
      chk("reset_mag_bin", 32'(mag_bin), 32'(0));
      chk("reset_mag_last", 32'(mag_last), 32'(0));
      chk("reset_mag_valid", 32'(mag_valid), 32'(0));
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_overrun", 32'(overrun), 32'(0));
      cycle();
      reset     = 1'b0;
      mag_ready = 1'b1;
      cycle();

      // table-driven frames, including the 17-bit extreme magnitudes
      for (int i = 0; i < 8; i++) begin
         default_tab();
         re_tab[vecs[i].bin] = 16'(vecs[i].re);
         im_tab[vecs[i].bin] = 16'(vecs[i].im);
         hs_before = n_hs;
         for (int s = 0; s < FL; s++) send(8'($urandom));
         wait_idle("table");
         chk("table_hs_count", 32'(n_hs - hs_before), 32'(NB));
         chk($sformatf("table_mag_row%0d", i), 32'(cap_mag[vecs[i].bin]), 32'(vecs[i].exp_mag));
      end

      // backpressure on bin 2 for five cycles
      default_tab();
      held = 0;
      for (int s = 0; s < FL; s++) send(8'(s + 1));
      n = 0;
      while ((m_busy || busy) && n < 300) begin
         if (mag_valid && mag_bin == 2'd2 && held < 5) begin
            mag_ready = 1'b0;
            held++;
            chk("bp_data", 32'(mag_data), 32'(26));
            chk("bp_addr", 32'(bin_addr), 32'(2));
         end else begin
            mag_ready = 1'b1;
         end
         cycle();
         n++;
      end
      mag_ready = 1'b1;
      chk("bp_timeout", 32'(n < 300), 32'(1));
      chk("bp_held_cycles", 32'(held), 32'(5));

      // one sample during a scan: held, drained, counts toward next frame
      for (int s = 0; s < FL; s++) send(8'(-s - 5));
      chk("scan_busy", 32'(busy), 32'(1));
      send(8'sd77);
      wait_idle("held1");
      chk("held_no_overrun", 32'(overrun), 32'(0));
      send(8'sd1);
      send(8'sd2);
      sample_in    = 8'sd3;
      sample_valid = 1'b1;
      cycle();
      sample_valid = 1'b0;
      chk("counter_one_after_drain", 32'(busy), 32'(1));
      wait_idle("held1b");

      // new sample in the drain cycle while the buffer is full
      for (int s = 0; s < FL; s++) send(8'(s + 20));
      send(-8'sd40);
      n = 0;
      while (!m_drain && n < 300) begin
         cycle();
         n++;
      end
      chk("drain_wait_timeout", 32'(n < 300), 32'(1));
      sample_in    = 8'sd99;
      sample_valid = 1'b1;
      cycle();
      sample_valid = 1'b0;
      cycle();
      chk("drain_collision_no_overrun", 32'(overrun), 32'(0));
      send(8'sd5);
      send(8'sd6);
      wait_idle("drain");

      // two samples during a scan: one kept, one dropped
      for (int s = 0; s < FL; s++) send(8'(s + 30));
      send(8'sd11);
      send(8'sd12);
      wait_idle("over");
      chk("overrun_set", 32'(overrun), 32'(1));

      // reset while holding bin 1 in the output stage
      for (int s = 0; s < FL - 1; s++) send(8'(s + 50));
      n = 0;
      while (!(mag_valid && mag_bin == 2'd1) && n < 300) begin
         cycle();
         n++;
      end
      chk("reset_wait_timeout", 32'(n < 300), 32'(1));
      mag_ready = 1'b0;
      cycle();
      #2;
      reset = 1'b1;
      #1;
      chk("midscan_mag_valid", 32'(mag_valid), 32'(0));
      chk("midscan_busy", 32'(busy), 32'(0));
      chk("midscan_overrun", 32'(overrun), 32'(0));
      model_reset();
      cycle();
      cycle();
      reset     = 1'b0;
      mag_ready = 1'b1;
      hs_before = n_hs;
      for (int s = 0; s < FL; s++) send(8'(s + 60));
      wait_idle("after_reset");
      chk("after_reset_hs_count", 32'(n_hs - hs_before), 32'(NB));

      // randomized traffic against the model
      for (int k = 0; k < NB; k++) begin
         re_tab[k] = 16'($urandom);
         im_tab[k] = 16'($urandom);
      end
      for (int c = 0; c < 1500; c++) begin
         sample_valid = ($urandom_range(0, 2) == 0);
         sample_in    = 8'($urandom);
         mag_ready    = ($urandom_range(0, 3) != 0);
         cycle();
      end
      sample_valid = 1'b0;
      mag_ready    = 1'b1;
      wait_idle("random");
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
